serial_sub: RTL
===============

# serial_sub

Parametrised bit-serial subtractor that generalises the single-bit full-subtractor cell to WIDTH-bit operands. One full-subtractor cell plus a borrow flip-flop is reused across WIDTH clock cycles under a small FSM. A start/busy/done handshake lets it sit behind a controller or testbench that issues one subtraction at a time. Computes D = X − Y − Bin with final borrow B.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when not busy.
- X  input  WIDTH  minuend; captured on accepted start.
- Y  input  WIDTH  subtrahend; captured on accepted start.
- Bin  input  1  borrow-in; captured on accepted start.
- busy  output  1  high while shifting.
- done  output  1  one-cycle completion pulse.
- D  output  WIDTH  difference; updated only on completion, held otherwise.
- B  output  1  final borrow-out; updated with D.
- OVF  output  1  signed overflow; present only with SERIAL_SUB_OVF_EN.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 → latch X, Y into shift registers.
  - Borrow flop ← Bin; bit counter ← 0.
  - Go to SHIFT.
- SHIFT, each cycle:
  - x = LSB of X register; y = LSB of Y register; b = borrow flop.
  - d = x^y^b.
  - b' = (~x&y) | (~(x^y)&b).
  - Both operand registers shift right.
  - d shifts into the MSB of the partial-result register.
  - Borrow flop ← b'; counter increments.
- On the WIDTH-th SHIFT edge:
  - D ← completed partial result; B ← b'.
  - Go to DONE.
- DONE lasts one cycle (done=1):
  - start=1 → accepted exactly as in IDLE, go to SHIFT.
  - Otherwise go to IDLE.
- start while busy is ignored; operands in flight are unaffected.
- D, B, OVF hold the last result until the next completion. They never show partial values.
- Arithmetic is modulo 2^WIDTH. B=1 iff X < Y+Bin (unsigned).
- Counter width is clog2(WIDTH+1). Counter wraps to 0 on leaving SHIFT.

## Timing
- Reset (asynchronous, any state, including mid-SHIFT):
  - state=IDLE; busy=0, done=0, D=0, B=0, OVF=0.
  - All internal registers cleared; the in-flight operation is discarded.
  - First accepted start after rst deasserts behaves normally.
- Latency: start accepted at edge k; busy=1 from edge k to edge k+WIDTH.
- At edge k+WIDTH: D/B update, busy falls, done rises.
- done is high for exactly one cycle, until edge k+WIDTH+1.
- Throughput: with start held high, a new operation is accepted at the DONE edge. One result every WIDTH+1 cycles.
- Inputs X, Y, Bin are don't-care except on the accepting edge.

## Configuration
- SERIAL_SUB_OVF_EN defined:
  - OVF port and logic present.
  - OVF ← (borrow into the MSB step) XOR (borrow out of the MSB step), i.e. two's-complement overflow.
  - OVF updates with D/B and holds.
- Undefined: the OVF port does not exist and no overflow logic is built. D/B behaviour is identical.

## Test plan
- WIDTH=8, X=0x05, Y=0x03, Bin=0, start pulse → busy for 8 cycles, then done=1 for one cycle with D=0x02, B=0.
- WIDTH=8, X=0x03, Y=0x05, Bin=0 → D=0xFE, B=1. Then X=0x00, Y=0x00, Bin=1 → D=0xFF, B=1.
- Start pulse with X=0x10, Y=0x01 issued mid-operation (cycle 3 of 8) → ignored; the first result completes unchanged. D/B hold prior values until completion.
- rst asserted at cycle 4 of SHIFT → busy=0, done=0, D=0, B=0 immediately. A subsequent start with X=0x09, Y=0x04 → D=0x05, B=0.
- start held high, X=0x80, Y=0x01 → results every 9 cycles, each D=0x7F, B=0. With SERIAL_SUB_OVF_EN, OVF=1. With X=0x7F, Y=0x01 → OVF=0.
- WIDTH=3 exhaustive sweep of all X, Y, Bin (128 cases) → {B,D} equals (X − Y − Bin) mod 16 in every case. This reproduces the single-bit truth table at the LSB.

Source files
------------

// File: rtl/serial_sub.sv
// Bit-serial subtractor: one full-subtractor cell reused over WIDTH cycles.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output OVF.
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             B
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             OVF
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_p;
    logic [WIDTH-1:0] r_d;
    logic             r_b;
    logic             r_bo;
    logic [CW-1:0]    r_cnt;

    logic             w_xb;
    logic             w_yb;
    logic             w_d;
    logic             w_bn;
    logic             w_accept;
    logic             w_last;

    // Full-subtractor cell on the operand LSBs
    assign w_xb = r_x[0];
    assign w_yb = r_y[0];
    assign w_d  = w_xb ^ w_yb ^ r_b;
    assign w_bn = (~w_xb & w_yb) | (~(w_xb ^ w_yb) & r_b);

    assign w_accept = start & (r_state != S_SHIFT);
    assign w_last   = (r_state == S_SHIFT) && (r_cnt == CW'(WIDTH - 1));

    assign busy = (r_state == S_SHIFT);
    assign done = (r_state == S_DONE);
    assign D    = r_d;
    assign B    = r_bo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = start ? S_SHIFT : S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x   <= '0;
            r_y   <= '0;
            r_p   <= '0;
            r_b   <= 1'b0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_x   <= X;
            r_y   <= Y;
            r_p   <= '0;
            r_b   <= Bin;
            r_cnt <= '0;
        end else if (r_state == S_SHIFT) begin
            r_x   <= r_x >> 1;
            r_y   <= r_y >> 1;
            r_p   <= {w_d, r_p[WIDTH-1:1]};
            r_b   <= w_bn;
            r_cnt <= w_last ? '0 : r_cnt + CW'(1);
        end
    end

    // Visible result only changes on the final shift step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d  <= '0;
            r_bo <= 1'b0;
        end else if (w_last) begin
            r_d  <= {w_d, r_p[WIDTH-1:1]};
            r_bo <= w_bn;
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic r_ovf;

    // Borrow into the MSB step differs from borrow out of it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= r_b ^ w_bn;
        end
    end

    assign OVF = r_ovf;
`endif

endmodule
